// File: rtl/turbo_blk_ctrl.sv
// Turbo encoder front end: buffers K info bits, then steps both RSC encoders (natural + QPP order) and 3 tail steps.
// Optional macro TBC_BLK_CNT_EN adds a saturating completed-block counter output blk_cnt.
module turbo_blk_ctrl #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10,
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        enc_ready,
  output logic        enc_clr,
  output logic        enc_en,
  output logic        enc_term,
  output logic        enc_u1,
  output logic        enc_u2,
  output logic        blk_start,
  output logic        blk_end,
  output logic        busy
`ifdef TBC_BLK_CNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, START, ENCODE, TAIL, DONE} state_t;

  localparam logic [AW-1:0] KL   = AW'(K);
  localparam logic [AW-1:0] LAST = AW'(K - 1);
  localparam logic [AW-1:0] G0   = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] D2   = AW'((2 * F2) % K);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_cnt, idx, pi, g;
  logic [1:0]    t;
  logic          mem [K];
  logic          accept, load_phase;
  logic          u1_rd, u2_rd;
  logic [AW:0]   pi_sum, g_sum;
  logic [AW-1:0] pi_nxt, g_nxt;

  // in_ready is forced low while reset is asserted, even though the state reads IDLE.
  assign load_phase = (state == IDLE) || (state == LOAD);
  assign in_ready   = clr_n & load_phase;
  assign accept     = in_valid & in_ready;

  // QPP recurrence: both operands are below K, so one conditional subtract wraps the sum.
  always_comb begin
    pi_sum = {1'b0, pi} + {1'b0, g};
    g_sum  = {1'b0, g} + {1'b0, D2};
    pi_nxt = (pi_sum >= {1'b0, KL}) ? AW'(pi_sum - {1'b0, KL}) : AW'(pi_sum);
    g_nxt  = (g_sum  >= {1'b0, KL}) ? AW'(g_sum  - {1'b0, KL}) : AW'(g_sum);
  end

  always_comb begin
    u1_rd = 1'b0;
    u2_rd = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (idx == AW'(j)) u1_rd = mem[j];
      if (pi  == AW'(j)) u2_rd = mem[j];
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < K; j++) begin
      if (accept && (wr_cnt == AW'(j))) mem[j] <= in_bit;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      wr_cnt <= '0;
      idx    <= '0;
      pi     <= '0;
      g      <= G0;
      t      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, LOAD: if (accept) wr_cnt <= wr_cnt + 1'b1;
        START: begin
          wr_cnt <= '0;
          idx    <= '0;
          pi     <= '0;
          g      <= G0;
          t      <= '0;
        end
        ENCODE: if (enc_ready) begin
          idx <= idx + 1'b1;
          pi  <= pi_nxt;
          g   <= g_nxt;
        end
        TAIL: if (enc_ready) t <= t + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    enc_clr   = 1'b0;
    enc_en    = 1'b0;
    enc_term  = 1'b0;
    enc_u1    = 1'b0;
    enc_u2    = 1'b0;
    blk_start = 1'b0;
    blk_end   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: if (accept && (wr_cnt == LAST)) state_nxt = START;
      START: begin
        enc_clr   = 1'b1;
        blk_start = 1'b1;
        busy      = 1'b1;
        state_nxt = ENCODE;
      end
      ENCODE: begin
        busy   = 1'b1;
        enc_en = enc_ready;
        enc_u1 = u1_rd;
        enc_u2 = u2_rd;
        if (enc_ready && (idx == LAST)) state_nxt = TAIL;
      end
      TAIL: begin
        busy     = 1'b1;
        enc_term = 1'b1;
        enc_en   = enc_ready;
        if (enc_ready && (t == 2'd2)) begin
          blk_end   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TBC_BLK_CNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      blk_cnt <= '0;
    end else if (blk_end && (blk_cnt != 16'hFFFF)) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_turbo_blk_ctrl.sv
// Scoreboard bench for turbo_blk_ctrl: random blocks, QPP reference model, stall and mid-block reset scenarios.
module tb_turbo_blk_ctrl;
  localparam int K  = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic enc_ready = 1'b0;
  logic in_ready, enc_clr, enc_en, enc_term, enc_u1, enc_u2, blk_start, blk_end, busy;
`ifdef TBC_BLK_CNT_EN
  logic [15:0] blk_cnt;
`endif

  turbo_blk_ctrl #(.K(K), .F1(F1), .F2(F2), .AW(AW)) dut (
    .clk(clk), .clr_n(clr_n), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .enc_ready(enc_ready), .enc_clr(enc_clr), .enc_en(enc_en), .enc_term(enc_term),
    .enc_u1(enc_u1), .enc_u2(enc_u2), .blk_start(blk_start), .blk_end(blk_end), .busy(busy)
`ifdef TBC_BLK_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic term; logic u1; logic u2; logic bend;} exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t expq[$];
  bit   blk[$];
  int   hold = 0;        // 0: accepting, 1: START..TAIL, 2: DONE cycle
  int   hold_old;
  bit   clr_due = 0;
  bit   chk_span = 0;
  int   busy_run = 0;
  int   steps = 0;
  int   blocks_done = 0;
  int   blocks_exp = 0;
  int   blocks_base = 0;
  int   rmode = 0;
  exp_t e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int pi_of(input int i);
    return (F1 * i + F2 * i * i) % K;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!clr_n) begin
      expq.delete();
      blk.delete();
      hold     = 0;
      clr_due  = 0;
      busy_run = 0;
      steps    = 0;
    end else begin
      hold_old = hold;
      check("in_ready", in_ready, hold == 0);
      check("busy", busy, hold != 0);
      check("enc_clr", enc_clr, clr_due);
      check("blk_start", blk_start, clr_due);
      if (hold == 1 && !clr_due) check("enc_en", enc_en, enc_ready);
      else check("enc_en_idle", enc_en, 0);
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        if (chk_span) check("busy_span", busy_run, K + 5);
        busy_run = 0;
      end
      if (enc_en) begin
        if (expq.size() == 0) check("unexpected_step", 1, 0);
        else begin
          e = expq.pop_front();
          check("enc_step{term,u1,u2,end}", {enc_term, enc_u1, enc_u2, blk_end}, e);
        end
        steps++;
      end else begin
        check("blk_end_idle", blk_end, 0);
      end
      clr_due = 0;
      if (hold == 2) hold = 0;
      else if (hold == 1 && enc_en && blk_end) begin
        hold = 2;
        blocks_done++;
      end
      if (hold_old == 0 && in_valid && in_ready) begin
        blk.push_back(in_bit);
        if (blk.size() == K) begin
          for (int j = 0; j < K; j++)
            expq.push_back(exp_t'({1'b0, blk[j], blk[pi_of(j)], 1'b0}));
          for (int s = 0; s < 3; s++)
            expq.push_back(exp_t'({1'b1, 1'b0, 1'b0, s == 2}));
          blk.delete();
          hold    = 1;
          clr_due = 1;
          steps   = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: enc_ready = 1'b1;
        1: enc_ready = ~enc_ready;
        default: enc_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // mode 0: random bits, 1: all ones, 2: single one at index 13
  task automatic send_bits(input int n, input int mode, input bit gaps);
    bit acc;
    int to;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      case (mode)
        1: in_bit = 1'b1;
        2: in_bit = ((k % K) == 13);
        default: in_bit = 1'($urandom_range(0, 1));
      endcase
      to = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        to++;
      end while (!acc && to < 500);
      if (!acc) begin
        check("send_timeout", to, 0);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int to = 0;
    while ((hold != 0 || expq.size() != 0) && to < 3000) begin
      @(posedge clk);
      to++;
    end
    if (to >= 3000) check("idle_timeout", to, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int to;
    #12;
    check("rst_outputs", {in_ready, enc_clr, enc_en, enc_term, enc_u1, enc_u2, blk_start, blk_end, busy}, 0);
    @(posedge clk);
    #1 clr_n = 1'b1;

    rmode = 0; chk_span = 1;
    send_bits(K, 1, 0); blocks_exp++;
    wait_idle();
    chk_span = 0;

    send_bits(K, 2, 0); blocks_exp++;
    wait_idle();

    rmode = 1;
    send_bits(K, 0, 0); blocks_exp++;
    wait_idle();

    rmode = 2;
    send_bits(2 * K, 0, 1); blocks_exp += 2;
    wait_idle();

    rmode = 0;
    send_bits(K, 0, 1);
    to = 0;
    while (steps < 20 && to < 1000) begin
      @(posedge clk);
      to++;
    end
    check("step20_reached", steps >= 20, 1);
    #2;
    check("busy_pre_rst", busy, 1);
    clr_n = 1'b0;
    #1;
    check("async_rst_outputs", {in_ready, enc_clr, enc_en, enc_term, enc_u1, enc_u2, blk_start, blk_end, busy}, 0);
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b1;
    blocks_base = blocks_done;

    rmode = 2;
    send_bits(K, 0, 0); blocks_exp++;
    wait_idle();

    rmode = 0;
    send_bits(2 * K, 0, 0); blocks_exp += 2;
    wait_idle();

    check("blocks_done", blocks_done, blocks_exp);
    check("queue_empty", expq.size(), 0);
`ifdef TBC_BLK_CNT_EN
    check("blk_cnt", blk_cnt, blocks_done - blocks_base);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
